// File: rtl/reservation_station.sv
// Reservation station: age-ordered collapsing queue that snoops two CDBs for operand wakeup
// and dispatches the oldest ready entry to a single functional unit.

module rs_src_wake #(
  parameter int XLEN = 32,
  parameter int RN_W = 6
) (
  input  logic            rdy,
  input  logic [RN_W-1:0] rrn,
  input  logic [XLEN-1:0] data,
  input  logic            cdb1_we,
  input  logic [RN_W-1:0] cdb1_rrn,
  input  logic [XLEN-1:0] cdb1_data,
  input  logic            cdb2_we,
  input  logic [RN_W-1:0] cdb2_rrn,
  input  logic [XLEN-1:0] cdb2_data,
  output logic            rdy_nxt,
  output logic [XLEN-1:0] data_nxt
);
  always_comb begin
    rdy_nxt  = rdy;
    data_nxt = data;
    // cdb1 has priority when both buses carry the awaited tag
    if (!rdy && cdb1_we && cdb1_rrn == rrn) begin
      rdy_nxt  = 1'b1;
      data_nxt = cdb1_data;
    end else if (!rdy && cdb2_we && cdb2_rrn == rrn) begin
      rdy_nxt  = 1'b1;
      data_nxt = cdb2_data;
    end
  end
endmodule

module reservation_station #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int RN_W  = 6,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [XLEN-1:0] issue_address,
  input  logic [RN_W-1:0] issue_rrn,
  input  logic            issue_tag,
  input  logic            issue_s1_rdy,
  input  logic [RN_W-1:0] issue_s1_rrn,
  input  logic [XLEN-1:0] issue_s1_data,
  input  logic            issue_s2_rdy,
  input  logic [RN_W-1:0] issue_s2_rrn,
  input  logic [XLEN-1:0] issue_s2_data,
  input  logic            cdb1_we,
  input  logic [RN_W-1:0] cdb1_rrn,
  input  logic [XLEN-1:0] cdb1_data,
  input  logic            cdb2_we,
  input  logic [RN_W-1:0] cdb2_rrn,
  input  logic [XLEN-1:0] cdb2_data,
  input  logic            clear_tags,
  input  logic            delete_tagged,
  output logic            disp_valid,
  input  logic            disp_ready,
  output logic [XLEN-1:0] disp_address,
  output logic [RN_W-1:0] disp_rrn,
  output logic [XLEN-1:0] disp_s1,
  output logic [XLEN-1:0] disp_s2,
  output logic [CW-1:0]   count
);
  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [RN_W-1:0] rrn;
    logic            tag;
    logic            s1_rdy;
    logic [RN_W-1:0] s1_rrn;
    logic [XLEN-1:0] s1_data;
    logic            s2_rdy;
    logic [RN_W-1:0] s2_rrn;
    logic [XLEN-1:0] s2_data;
  } rs_entry_t;

  rs_entry_t       q     [DEPTH];
  rs_entry_t       q_nxt [DEPTH];
  rs_entry_t       cand  [DEPTH+1];  // slots 0..DEPTH-1 plus the incoming issue at DEPTH
  rs_entry_t       woken [DEPTH+1];
  logic [DEPTH:0]  w1_rdy, w2_rdy;
  logic [XLEN-1:0] w1_data [DEPTH+1];
  logic [XLEN-1:0] w2_data [DEPTH+1];
  logic [DEPTH-1:0] valid;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            fire, accept, store, keep;
  logic [CW-1:0]   n, count_nxt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) cand[i] = q[i];
    cand[DEPTH] = '{address: issue_address, rrn: issue_rrn, tag: issue_tag,
                    s1_rdy: issue_s1_rdy, s1_rrn: issue_s1_rrn, s1_data: issue_s1_data,
                    s2_rdy: issue_s2_rdy, s2_rrn: issue_s2_rrn, s2_data: issue_s2_data};
  end

  for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
    rs_src_wake #(.XLEN(XLEN), .RN_W(RN_W)) u_s1 (
      .rdy(cand[g].s1_rdy), .rrn(cand[g].s1_rrn), .data(cand[g].s1_data),
      .cdb1_we(cdb1_we), .cdb1_rrn(cdb1_rrn), .cdb1_data(cdb1_data),
      .cdb2_we(cdb2_we), .cdb2_rrn(cdb2_rrn), .cdb2_data(cdb2_data),
      .rdy_nxt(w1_rdy[g]), .data_nxt(w1_data[g]));
    rs_src_wake #(.XLEN(XLEN), .RN_W(RN_W)) u_s2 (
      .rdy(cand[g].s2_rdy), .rrn(cand[g].s2_rrn), .data(cand[g].s2_data),
      .cdb1_we(cdb1_we), .cdb1_rrn(cdb1_rrn), .cdb1_data(cdb1_data),
      .cdb2_we(cdb2_we), .cdb2_rrn(cdb2_rrn), .cdb2_data(cdb2_data),
      .rdy_nxt(w2_rdy[g]), .data_nxt(w2_data[g]));
  end

  always_comb begin
    for (int i = 0; i <= DEPTH; i++) begin
      woken[i]         = cand[i];
      woken[i].s1_rdy  = w1_rdy[i];
      woken[i].s1_data = w1_data[i];
      woken[i].s2_rdy  = w2_rdy[i];
      woken[i].s2_data = w2_data[i];
    end
  end

  // Select uses stored readiness, so a freshly captured operand dispatches one cycle later
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = (CW'(i) < count);
      if (!sel_found && valid[i] && q[i].s1_rdy && q[i].s2_rdy && !(q[i].tag && delete_tagged)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign issue_ready  = (count < CW'(DEPTH));
  assign disp_valid   = sel_found;
  assign disp_address = sel_found ? q[sel_idx].address : '0;
  assign disp_rrn     = sel_found ? q[sel_idx].rrn     : '0;
  assign disp_s1      = sel_found ? q[sel_idx].s1_data : '0;
  assign disp_s2      = sel_found ? q[sel_idx].s2_data : '0;

  assign fire   = disp_valid && disp_ready;
  assign accept = issue_valid && issue_ready;
  assign store  = accept && !(delete_tagged && issue_tag);

  // Compact survivors toward slot 0, then append the new entry at the compacted count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) q_nxt[i] = q[i];
    n    = '0;
    keep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = valid[i] && !(fire && sel_idx == IW'(i)) && !(delete_tagged && q[i].tag);
      if (keep) begin
        q_nxt[n[IW-1:0]] = woken[i];
        if (clear_tags) q_nxt[n[IW-1:0]].tag = 1'b0;
        n = n + 1'b1;
      end
    end
    if (store) begin
      q_nxt[n[IW-1:0]]     = woken[DEPTH];
      q_nxt[n[IW-1:0]].tag = issue_tag && !clear_tags;
    end
    count_nxt = n + {{(CW-1){1'b0}}, store};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, CDB wakeup, bypass, fill/compaction,
// speculation flush/clear and asynchronous reset.

module tb_reservation_station;
  logic        clk, reset;
  logic        issue_valid, issue_ready, issue_tag;
  logic [31:0] issue_address, issue_s1_data, issue_s2_data;
  logic [5:0]  issue_rrn, issue_s1_rrn, issue_s2_rrn;
  logic        issue_s1_rdy, issue_s2_rdy;
  logic        cdb1_we, cdb2_we;
  logic [5:0]  cdb1_rrn, cdb2_rrn;
  logic [31:0] cdb1_data, cdb2_data;
  logic        clear_tags, delete_tagged;
  logic        disp_valid, disp_ready;
  logic [31:0] disp_address, disp_s1, disp_s2;
  logic [5:0]  disp_rrn;
  logic [3:0]  count;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_a [5];

  reservation_station #(.DEPTH(8), .XLEN(32), .RN_W(6)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_address(issue_address),
    .issue_rrn(issue_rrn), .issue_tag(issue_tag),
    .issue_s1_rdy(issue_s1_rdy), .issue_s1_rrn(issue_s1_rrn), .issue_s1_data(issue_s1_data),
    .issue_s2_rdy(issue_s2_rdy), .issue_s2_rrn(issue_s2_rrn), .issue_s2_data(issue_s2_data),
    .cdb1_we(cdb1_we), .cdb1_rrn(cdb1_rrn), .cdb1_data(cdb1_data),
    .cdb2_we(cdb2_we), .cdb2_rrn(cdb2_rrn), .cdb2_data(cdb2_data),
    .clear_tags(clear_tags), .delete_tagged(delete_tagged),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_address(disp_address),
    .disp_rrn(disp_rrn), .disp_s1(disp_s1), .disp_s2(disp_s2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one issue for a single edge, then withdraws it
  task automatic issue_go(input logic [31:0] a, input logic [5:0] r, input logic t,
                          input logic s1r, input logic [5:0] s1n, input logic [31:0] s1d,
                          input logic s2r, input logic [5:0] s2n, input logic [31:0] s2d);
    issue_valid = 1'b1; issue_address = a; issue_rrn = r; issue_tag = t;
    issue_s1_rdy = s1r; issue_s1_rrn = s1n; issue_s1_data = s1d;
    issue_s2_rdy = s2r; issue_s2_rrn = s2n; issue_s2_data = s2d;
    step();
    issue_valid = 1'b0; issue_tag = 1'b0;
  endtask

  task automatic drain_one();
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_address = 0; issue_rrn = 0; issue_tag = 0;
    issue_s1_rdy = 0; issue_s1_rrn = 0; issue_s1_data = 0;
    issue_s2_rdy = 0; issue_s2_rrn = 0; issue_s2_data = 0;
    cdb1_we = 0; cdb1_rrn = 0; cdb1_data = 0; cdb2_we = 0; cdb2_rrn = 0; cdb2_data = 0;
    clear_tags = 0; delete_tagged = 0; disp_ready = 0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_disp_s1", disp_s1, 0);
    step();
    reset = 1'b1;

    // 1: ready-at-issue dispatch
    issue_go(32'h100, 6'd5, 0, 1, 6'd0, 32'd7, 1, 6'd0, 32'd9);
    chk("t1_valid", disp_valid, 1);
    chk("t1_addr", disp_address, 32'h100);
    chk("t1_s1", disp_s1, 7);
    chk("t1_s2", disp_s2, 9);
    chk("t1_rrn", disp_rrn, 5);
    drain_one();
    chk("t1_count", count, 0);
    chk("t1_valid_after", disp_valid, 0);

    // 2: wakeup from cdb2, then cdb1 priority
    issue_go(32'h200, 6'd1, 0, 0, 6'd12, 32'd0, 1, 6'd0, 32'd3);
    chk("t2_count", count, 1);
    chk("t2_wait", disp_valid, 0);
    step();
    cdb2_we = 1; cdb2_rrn = 6'd12; cdb2_data = 32'hAB;
    chk("t2_same_cycle", disp_valid, 0);
    step();
    cdb2_we = 0;
    chk("t2_valid", disp_valid, 1);
    chk("t2_s1", disp_s1, 32'hAB);
    chk("t2_s2", disp_s2, 3);
    drain_one();
    chk("t2_count0", count, 0);
    issue_go(32'h210, 6'd2, 0, 0, 6'd12, 32'd0, 1, 6'd0, 32'd4);
    cdb1_we = 1; cdb1_rrn = 6'd12; cdb1_data = 32'h1;
    cdb2_we = 1; cdb2_rrn = 6'd12; cdb2_data = 32'h2;
    step();
    cdb1_we = 0; cdb2_we = 0;
    chk("t2_cdb1_wins", disp_s1, 32'h1);
    drain_one();

    // 3: issue-time bypass
    cdb1_we = 1; cdb1_rrn = 6'd3; cdb1_data = 32'h55;
    issue_go(32'h300, 6'd8, 0, 0, 6'd3, 32'd0, 1, 6'd0, 32'd6);
    cdb1_we = 0;
    chk("t3_valid", disp_valid, 1);
    chk("t3_s1", disp_s1, 32'h55);
    drain_one();
    chk("t3_count", count, 0);

    // 4: fill, full-with-dispatch, ordered drain
    for (int k = 0; k < 8; k++)
      issue_go(32'h400 + 32'(k * 4), 6'(k), 0, 1, 6'd0, 32'(k), 1, 6'd0, 32'd0);
    chk("t4_full_count", count, 8);
    chk("t4_full_ready", issue_ready, 0);
    chk("t4_head", disp_address, 32'h400);
    issue_valid = 1; issue_address = 32'h4FF; disp_ready = 1;
    chk("t4_no_bypass", issue_ready, 0);
    step();
    issue_valid = 0; disp_ready = 0;
    chk("t4_count7", count, 7);
    chk("t4_ready_again", issue_ready, 1);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t4_order%0d", k), disp_address, 32'h400 + 32'(k * 4));
      drain_one();
    end
    chk("t4_empty", count, 0);

    // 5a: flush tagged entries, tagged issue discarded
    issue_go(32'h500, 6'd1, 0, 1, 0, 1, 1, 0, 1);
    issue_go(32'h504, 6'd2, 1, 1, 0, 2, 1, 0, 2);
    issue_go(32'h508, 6'd3, 0, 1, 0, 3, 1, 0, 3);
    issue_go(32'h50C, 6'd4, 1, 1, 0, 4, 1, 0, 4);
    delete_tagged = 1;
    issue_go(32'h510, 6'd5, 1, 1, 0, 5, 1, 0, 5);
    delete_tagged = 0;
    chk("t5_flush_count", count, 2);
    chk("t5_first", disp_address, 32'h500);
    drain_one();
    chk("t5_second", disp_address, 32'h508);
    drain_one();
    chk("t5_empty", count, 0);

    // 5b: clear tags, later flush has no effect
    issue_go(32'h500, 6'd1, 0, 1, 0, 1, 1, 0, 1);
    issue_go(32'h504, 6'd2, 1, 1, 0, 2, 1, 0, 2);
    issue_go(32'h508, 6'd3, 0, 1, 0, 3, 1, 0, 3);
    issue_go(32'h50C, 6'd4, 1, 1, 0, 4, 1, 0, 4);
    clear_tags = 1;
    issue_go(32'h510, 6'd5, 1, 1, 0, 5, 1, 0, 5);
    clear_tags = 0;
    chk("t5_clear_count", count, 5);
    delete_tagged = 1;
    step();
    delete_tagged = 0;
    chk("t5_del_noeffect", count, 5);
    exp_a = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h510};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_order%0d", k), disp_address, exp_a[k]);
      drain_one();
    end
    chk("t5_drained", count, 0);

    // 6: asynchronous reset mid-operation
    for (int k = 0; k < 5; k++)
      issue_go(32'h600 + 32'(k * 4), 6'(k), 0, 1, 0, 32'(k + 1), 1, 0, 0);
    chk("t6_pre_count", count, 5);
    chk("t6_pre_valid", disp_valid, 1);
    #2 reset = 0;
    #1;
    chk("t6_count", count, 0);
    chk("t6_valid", disp_valid, 0);
    chk("t6_ready", issue_ready, 1);
    chk("t6_s1", disp_s1, 0);
    cdb1_we = 1; cdb1_rrn = 6'd9; cdb1_data = 32'hDEAD;
    step();
    step();
    chk("t6_cdb_ignored", count, 0);
    cdb1_we = 0;
    reset = 1;
    step();
    chk("t6_after_count", count, 0);
    chk("t6_after_valid", disp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
